// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Brief    : Circular ROB: allocates tags, captures CDB results, serves operand
//            reads and retires completed entries in program order.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
  parameter int ROB_SZ = 8,
  parameter int TAG_W  = $clog2(ROB_SZ + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dispatch_valid,
  input  logic             dispatch_has_dest,
  input  logic [4:0]       dispatch_dest,
  output logic             rob_full,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic [TAG_W-1:0] src_tag_a,
  input  logic [TAG_W-1:0] src_tag_b,
  output logic             src_ready_a,
  output logic             src_ready_b,
  output logic [31:0]      src_value_a,
  output logic [31:0]      src_value_b,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             squash,
  output logic             retire_valid,
  output logic [TAG_W-1:0] retire_tag,
  output logic             retire_has_dest,
  output logic [4:0]       retire_dest,
  output logic [31:0]      retire_value,
  output logic [TAG_W-1:0] count
);

  localparam int c_IDX_W = $clog2(ROB_SZ);

  logic [ROB_SZ-1:0]  r_busy;
  logic [ROB_SZ-1:0]  r_done;
  logic [ROB_SZ-1:0]  r_has_dest;
  logic [4:0]         r_dest  [ROB_SZ];
  logic [31:0]        r_value [ROB_SZ];
  logic [c_IDX_W-1:0] r_head;
  logic [c_IDX_W-1:0] r_tail;
  logic [TAG_W-1:0]   r_count;

  logic               w_accept;
  logic               w_retire;
  logic               w_cdb_in_range;
  logic               w_cdb_hit;
  logic [c_IDX_W-1:0] w_cdb_idx;

  assign rob_full  = (r_count == TAG_W'(ROB_SZ));
  assign alloc_tag = TAG_W'(r_tail) + TAG_W'(1);
  assign count     = r_count;
  assign w_accept  = dispatch_valid && !rob_full;

  assign w_cdb_in_range = (cdb_tag != '0) && (cdb_tag <= TAG_W'(ROB_SZ));
  assign w_cdb_idx      = c_IDX_W'(cdb_tag - TAG_W'(1));
  assign w_cdb_hit      = cdb_valid && w_cdb_in_range && r_busy[w_cdb_idx];

  assign w_retire        = r_busy[r_head] && r_done[r_head];
  assign retire_valid    = w_retire;
  assign retire_tag      = TAG_W'(r_head) + TAG_W'(1);
  assign retire_has_dest = r_has_dest[r_head];
  assign retire_dest     = r_dest[r_head];
  assign retire_value    = r_value[r_head];

  // Returns {ready, value}; a result on the CDB this cycle is bypassed.
  function automatic logic [32:0] read_src(input logic [TAG_W-1:0] tag);
    logic [c_IDX_W-1:0] idx;
    idx = c_IDX_W'(tag - TAG_W'(1));
    if (tag == '0 || tag > TAG_W'(ROB_SZ)) begin
      return 33'd0;
    end else if (r_done[idx]) begin
      return {1'b1, r_value[idx]};
    end else if (cdb_valid && cdb_tag == tag) begin
      return {1'b1, cdb_value};
    end
    return 33'd0;
  endfunction

  always_comb begin
    {src_ready_a, src_value_a} = read_src(src_tag_a);
    {src_ready_b, src_value_b} = read_src(src_tag_b);
  end

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      r_busy     <= '0;
      r_done     <= '0;
      r_has_dest <= '0;
      for (int i = 0; i < ROB_SZ; i++) begin
        r_dest[i]  <= '0;
        r_value[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_busy[r_tail]     <= 1'b1;
        r_done[r_tail]     <= 1'b0;
        r_has_dest[r_tail] <= dispatch_has_dest;
        r_dest[r_tail]     <= dispatch_dest;
        r_tail             <= r_tail + c_IDX_W'(1);
      end
      if (w_cdb_hit) begin
        r_done[w_cdb_idx]  <= 1'b1;
        r_value[w_cdb_idx] <= cdb_value;
      end
      // Head clear comes last so it wins over a late CDB write to the same entry.
      if (w_retire) begin
        r_busy[r_head]     <= 1'b0;
        r_done[r_head]     <= 1'b0;
        r_has_dest[r_head] <= 1'b0;
        r_dest[r_head]     <= '0;
        r_value[r_head]    <= '0;
        r_head             <= r_head + c_IDX_W'(1);
      end
      case ({w_accept, w_retire})
        2'b10:   r_count <= r_count + TAG_W'(1);
        2'b01:   r_count <= r_count - TAG_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer
// Brief    : Directed self-checking bench for reorder_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

  localparam int ROB_SZ = 8;
  localparam int TAG_W  = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             dispatch_valid;
  logic             dispatch_has_dest;
  logic [4:0]       dispatch_dest;
  logic             rob_full;
  logic [TAG_W-1:0] alloc_tag;
  logic [TAG_W-1:0] src_tag_a;
  logic [TAG_W-1:0] src_tag_b;
  logic             src_ready_a;
  logic             src_ready_b;
  logic [31:0]      src_value_a;
  logic [31:0]      src_value_b;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic             squash;
  logic             retire_valid;
  logic [TAG_W-1:0] retire_tag;
  logic             retire_has_dest;
  logic [4:0]       retire_dest;
  logic [31:0]      retire_value;
  logic [TAG_W-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  reorder_buffer #(.ROB_SZ(ROB_SZ), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_has_dest(dispatch_has_dest),
    .dispatch_dest(dispatch_dest), .rob_full(rob_full), .alloc_tag(alloc_tag),
    .src_tag_a(src_tag_a), .src_tag_b(src_tag_b),
    .src_ready_a(src_ready_a), .src_ready_b(src_ready_b),
    .src_value_a(src_value_a), .src_value_b(src_value_b),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .squash(squash), .retire_valid(retire_valid), .retire_tag(retire_tag),
    .retire_has_dest(retire_has_dest), .retire_dest(retire_dest),
    .retire_value(retire_value), .count(count)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    dispatch_valid = 0; dispatch_has_dest = 0; dispatch_dest = '0;
    src_tag_a = '0; src_tag_b = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_value = '0; squash = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    if (count !== 4'd0) begin $display("FAIL reset_count: got %0d want 0", count); n_fail++; end
    n_checks++;
    if (rob_full !== 1'b0) begin $display("FAIL reset_full: got %b want 0", rob_full); n_fail++; end
    n_checks++;
    if (retire_valid !== 1'b0) begin $display("FAIL reset_retire_valid: got %b want 0", retire_valid); n_fail++; end
    n_checks++;
    if (alloc_tag !== 4'd1) begin $display("FAIL reset_alloc_tag: got %0d want 1", alloc_tag); n_fail++; end
    n_checks++;
  endtask

  task automatic test_single;
    do_reset();
    dispatch_valid = 1; dispatch_has_dest = 1; dispatch_dest = 5'd5;
    #1;
    if (alloc_tag !== 4'd1) begin $display("FAIL single_alloc: got %0d want 1", alloc_tag); n_fail++; end
    n_checks++;
    tick();
    dispatch_valid = 0;
    #1;
    if (count !== 4'd1) begin $display("FAIL single_count1: got %0d want 1", count); n_fail++; end
    n_checks++;
    if (retire_valid !== 1'b0) begin $display("FAIL single_early_retire: got %b want 0", retire_valid); n_fail++; end
    n_checks++;
    cdb_valid = 1; cdb_tag = 4'd1; cdb_value = 32'hAB;
    #1;
    if (retire_valid !== 1'b0) begin $display("FAIL single_no_bypass: got %b want 0", retire_valid); n_fail++; end
    n_checks++;
    tick();
    cdb_valid = 0;
    #1;
    if (retire_valid !== 1'b1) begin $display("FAIL single_retire_valid: got %b want 1", retire_valid); n_fail++; end
    n_checks++;
    if (retire_tag !== 4'd1) begin $display("FAIL single_retire_tag: got %0d want 1", retire_tag); n_fail++; end
    n_checks++;
    if (retire_dest !== 5'd5) begin $display("FAIL single_retire_dest: got %0d want 5", retire_dest); n_fail++; end
    n_checks++;
    if (retire_has_dest !== 1'b1) begin $display("FAIL single_retire_has_dest: got %b want 1", retire_has_dest); n_fail++; end
    n_checks++;
    if (retire_value !== 32'hAB) begin $display("FAIL single_retire_value: got %h want 000000ab", retire_value); n_fail++; end
    n_checks++;
    tick();
    if (count !== 4'd0) begin $display("FAIL single_count0: got %0d want 0", count); n_fail++; end
    n_checks++;
    if (retire_valid !== 1'b0) begin $display("FAIL single_empty_retire: got %b want 0", retire_valid); n_fail++; end
    n_checks++;
  endtask

  task automatic test_fill;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      dispatch_valid = 1; dispatch_has_dest = 1; dispatch_dest = 5'(i + 1);
      #1;
      if (alloc_tag !== 4'(i + 1)) begin $display("FAIL fill_alloc[%0d]: got %0d want %0d", i, alloc_tag, i + 1); n_fail++; end
      n_checks++;
      tick();
    end
    dispatch_dest = 5'd31;
    #1;
    if (rob_full !== 1'b1) begin $display("FAIL fill_full: got %b want 1", rob_full); n_fail++; end
    n_checks++;
    if (count !== 4'd8) begin $display("FAIL fill_count: got %0d want 8", count); n_fail++; end
    n_checks++;
    tick();
    dispatch_valid = 0;
    #1;
    if (count !== 4'd8) begin $display("FAIL fill_drop_count: got %0d want 8", count); n_fail++; end
    n_checks++;
    if (alloc_tag !== 4'd1) begin $display("FAIL fill_drop_tail: got %0d want 1", alloc_tag); n_fail++; end
    n_checks++;
    if (retire_valid !== 1'b0) begin $display("FAIL fill_retire_valid: got %b want 0", retire_valid); n_fail++; end
    n_checks++;
  endtask

  // Continues from the full buffer left by test_fill.
  task automatic test_in_order;
    cdb_valid = 1; cdb_tag = 4'd3; cdb_value = 32'h33;
    #1;
    tick();
    cdb_tag = 4'd1; cdb_value = 32'h11;
    #1;
    if (retire_valid !== 1'b0) begin $display("FAIL order_tag3_blocked: got %b want 0", retire_valid); n_fail++; end
    n_checks++;
    tick();
    cdb_valid = 0;
    #1;
    if (retire_valid !== 1'b1 || retire_tag !== 4'd1) begin
      $display("FAIL order_retire1: got valid=%b tag=%0d want valid=1 tag=1", retire_valid, retire_tag); n_fail++;
    end
    n_checks++;
    if (retire_value !== 32'h11) begin $display("FAIL order_value1: got %h want 00000011", retire_value); n_fail++; end
    n_checks++;
    tick();
    if (retire_valid !== 1'b0 || retire_tag !== 4'd2) begin
      $display("FAIL order_wait2: got valid=%b tag=%0d want valid=0 tag=2", retire_valid, retire_tag); n_fail++;
    end
    n_checks++;
    if (count !== 4'd7 || rob_full !== 1'b0) begin
      $display("FAIL order_count7: got count=%0d full=%b want count=7 full=0", count, rob_full); n_fail++;
    end
    n_checks++;
    cdb_valid = 1; cdb_tag = 4'd2; cdb_value = 32'h22;
    #1;
    tick();
    cdb_valid = 0;
    #1;
    if (retire_valid !== 1'b1 || retire_tag !== 4'd2 || retire_value !== 32'h22) begin
      $display("FAIL order_retire2: got valid=%b tag=%0d val=%h want 1/2/22", retire_valid, retire_tag, retire_value); n_fail++;
    end
    n_checks++;
    tick();
    if (retire_valid !== 1'b1 || retire_tag !== 4'd3 || retire_value !== 32'h33) begin
      $display("FAIL order_retire3: got valid=%b tag=%0d val=%h want 1/3/33", retire_valid, retire_tag, retire_value); n_fail++;
    end
    n_checks++;
    if (retire_dest !== 5'd3) begin $display("FAIL order_dest3: got %0d want 3", retire_dest); n_fail++; end
    n_checks++;
    if (count !== 4'd6) begin $display("FAIL order_count6: got %0d want 6", count); n_fail++; end
    n_checks++;
    tick();
    if (retire_valid !== 1'b0 || count !== 4'd5) begin
      $display("FAIL order_after: got valid=%b count=%0d want 0/5", retire_valid, count); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_bypass;
    do_reset();
    dispatch_valid = 1; dispatch_has_dest = 1; dispatch_dest = 5'd7;
    tick(); tick();
    dispatch_valid = 0;
    cdb_valid = 1; cdb_tag = 4'd1; cdb_value = 32'h77;
    #1;
    tick();
    src_tag_a = 4'd2; src_tag_b = 4'd0;
    cdb_valid = 1; cdb_tag = 4'd2; cdb_value = 32'h55;
    #1;
    if (src_ready_a !== 1'b1 || src_value_a !== 32'h55) begin
      $display("FAIL bypass_a: got ready=%b val=%h want 1/55", src_ready_a, src_value_a); n_fail++;
    end
    n_checks++;
    if (src_ready_b !== 1'b0 || src_value_b !== 32'h0) begin
      $display("FAIL bypass_b_tag0: got ready=%b val=%h want 0/0", src_ready_b, src_value_b); n_fail++;
    end
    n_checks++;
    src_tag_b = 4'd1;
    #1;
    if (src_ready_b !== 1'b1 || src_value_b !== 32'h77) begin
      $display("FAIL stored_b: got ready=%b val=%h want 1/77", src_ready_b, src_value_b); n_fail++;
    end
    n_checks++;
    cdb_valid = 0;
    #1;
    if (src_ready_a !== 1'b0 || src_value_a !== 32'h0) begin
      $display("FAIL not_ready_a: got ready=%b val=%h want 0/0", src_ready_a, src_value_a); n_fail++;
    end
    n_checks++;
    idle_inputs();
  endtask

  task automatic test_wrap;
    logic [4:0]  exp_dest [0:8];
    logic [31:0] exp_val  [0:8];
    int er, ea, t, s;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      dispatch_valid = 1; dispatch_has_dest = 1; dispatch_dest = 5'(i);
      exp_dest[i] = 5'(i);
      tick();
    end
    dispatch_valid = 0;
    cdb_valid = 1; cdb_tag = 4'd1; cdb_value = 32'h5A00_0001;
    exp_val[1] = 32'h5A00_0001;
    tick();
    er = 1; ea = 4; s = 4;
    for (int k = 0; k < 20; k++) begin
      t = (er % 8) + 1;
      dispatch_valid = 1; dispatch_dest = 5'(s);
      exp_dest[ea] = 5'(s);
      cdb_valid = 1; cdb_tag = 4'(t); cdb_value = 32'h5A00_0100 + 32'(k);
      exp_val[t] = 32'h5A00_0100 + 32'(k);
      #1;
      if (retire_valid !== 1'b1 || retire_tag !== 4'(er)) begin
        $display("FAIL wrap_retire[%0d]: got valid=%b tag=%0d want 1/%0d", k, retire_valid, retire_tag, er); n_fail++;
      end
      n_checks++;
      if (retire_dest !== exp_dest[er] || retire_value !== exp_val[er]) begin
        $display("FAIL wrap_data[%0d]: got dest=%0d val=%h want %0d/%h", k, retire_dest, retire_value, exp_dest[er], exp_val[er]); n_fail++;
      end
      n_checks++;
      if (alloc_tag !== 4'(ea)) begin $display("FAIL wrap_alloc[%0d]: got %0d want %0d", k, alloc_tag, ea); n_fail++; end
      n_checks++;
      if (count !== 4'd3) begin $display("FAIL wrap_count[%0d]: got %0d want 3", k, count); n_fail++; end
      n_checks++;
      tick();
      er = (er % 8) + 1; ea = (ea % 8) + 1; s++;
    end
    idle_inputs();
  endtask

  task automatic test_squash;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      dispatch_valid = 1; dispatch_has_dest = 1; dispatch_dest = 5'(10 + i);
      tick();
    end
    dispatch_valid = 0;
    cdb_valid = 1; cdb_tag = 4'd1; cdb_value = 32'h99;
    #1;
    tick();
    squash = 1; dispatch_valid = 1; cdb_valid = 1; cdb_tag = 4'd2; cdb_value = 32'h42;
    #1;
    if (retire_valid !== 1'b1 || count !== 4'd5) begin
      $display("FAIL squash_cycle: got valid=%b count=%0d want 1/5", retire_valid, count); n_fail++;
    end
    n_checks++;
    tick();
    idle_inputs();
    #1;
    if (count !== 4'd0 || rob_full !== 1'b0) begin
      $display("FAIL squash_count: got count=%0d full=%b want 0/0", count, rob_full); n_fail++;
    end
    n_checks++;
    if (alloc_tag !== 4'd1) begin $display("FAIL squash_alloc: got %0d want 1", alloc_tag); n_fail++; end
    n_checks++;
    if (retire_valid !== 1'b0) begin $display("FAIL squash_retire: got %b want 0", retire_valid); n_fail++; end
    n_checks++;
    cdb_valid = 1; cdb_tag = 4'd2; cdb_value = 32'h42;
    #1;
    tick();
    cdb_valid = 0; src_tag_a = 4'd2;
    #1;
    if (src_ready_a !== 1'b0 || src_value_a !== 32'h0) begin
      $display("FAIL squash_stale_cdb: got ready=%b val=%h want 0/0", src_ready_a, src_value_a); n_fail++;
    end
    n_checks++;
    if (retire_valid !== 1'b0 || count !== 4'd0) begin
      $display("FAIL squash_after: got valid=%b count=%0d want 0/0", retire_valid, count); n_fail++;
    end
    n_checks++;
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single();
    test_fill();
    test_in_order();
    test_bypass();
    test_wrap();
    test_squash();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
